pending_request_arbiter: RTL and testbench
==========================================

// Module: pending_request_arbiter
//
// PURPOSE
// Parametrised, registered successor to the combinational 32-input priority encoder.
// Latches incoming request pulses into sticky pending bits and applies a per-line enable mask.
// Selects one winner, by fixed (lowest index first) or round-robin priority.
// Presents the winner through a valid/ready grant handshake.
// Sits between interrupt/event sources and the CPU exception logic or a DMA channel sequencer.
//
// PARAMETERS
// WIDTH        32  number of request lines; 2 <= WIDTH <= 2**INDEX_WIDTH, non-power-of-two allowed
// INDEX_WIDTH   5  width of grantIndex
// ROUND_ROBIN   0  0 = fixed priority (index 0 highest); 1 = round-robin starting after last grant
//
// PORTS
// clock           in   1            single clock; all state changes on rising edge
// reset           in   1            synchronous, active-high
// requestPulses   in   WIDTH        1 in a cycle sets the corresponding pending bit
// requestMask     in   WIDTH        1 = line eligible for grant; masked lines stay pending
// grantReady      in   1            consumer accepts the current grant
// pendingSignals  out  WIDTH        registered pending bits (unmasked view)
// anyPending      out  1            |(pendingSignals & requestMask), combinational from registers
// grantValid      out  1            registered; grant offered
// grantIndex      out  INDEX_WIDTH  registered; index of granted line, stable while grantValid
//
// BEHAVIOUR
// - Reset state: pending = 0, grantValid = 0, grantIndex = 0, state IDLE, lastGranted = WIDTH-1.
//   Reset during an outstanding grant drops it; there is no acceptance.
// - Pending update each cycle: pending' = (pending & ~clr) | requestPulses.
//   clr = onehot(grantIndex) when grantValid && grantReady, else 0.
//   Set dominates: a pulse on the line being cleared leaves it pending.
// - FSM IDLE: eligible = pending & requestMask (registered pending, not this cycle's pulses).
//   If eligible != 0: grantIndex <= winner, grantValid <= 1, go to GRANT.
//   Otherwise stay in IDLE.
// - FSM GRANT: grantValid = 1, and grantIndex holds.
//   There is no preemption by higher-priority arrivals or mask changes.
//   On grantReady: clear the bit, lastGranted <= grantIndex, grantValid <= 0, go to IDLE.
//   Without grantReady, stay in GRANT indefinitely.
// - Throughput: at most one grant per 2 cycles (one IDLE bubble after each accept).
// - Latency: pulse at edge N -> pending at N+1 -> grantValid at N+2, when the line wins.
// - Fixed mode: winner = lowest set index of eligible.
// - Round-robin mode: winner = first set index scanning lastGranted+1 .. WIDTH-1, then wrapping 0 ..
//   lastGranted. After reset, behaves as fixed for the first grant.
// - lastGranted updates only on accept, in both modes; it is unused in fixed mode.
// - Indices >= WIDTH never appear on grantIndex.
//   grantIndex is zero-extended when WIDTH < 2**INDEX_WIDTH.
// - grantReady while grantValid = 0 is ignored.
//
// TESTING
// 1 Fixed: reset, pulse 32'h0000_0001 at edge N -> pendingSignals = 1 @N+1.
//   grantValid = 1 and grantIndex = 0 @N+2. Ready -> pending = 0 and grantValid = 0 on the next edge.
// 2 Fixed: pending 32'h8000_0006, mask all ones, ready held high -> grants 1, 2, 31 in order.
//   Each grant is 2 cycles apart, then anyPending = 0.
// 3 Mask: pending 32'h0000_0003 with mask 32'hFFFF_FFFE -> grant 1 only; bit 0 stays pending.
//   Set mask to all ones -> grant 0.
// 4 RR (ROUND_ROBIN=1, WIDTH=6): lines 0 and 5 re-pulsed every cycle -> grants 0, 5, 0, 5.
//   Fixed mode with the same stimulus -> 0, 0, 0.
// 5 Set-dominates: pulse bit 3 in the cycle grant 3 is accepted -> bit 3 still pending, re-granted.
//   Hold ready low with grant 4 offered, then pulse bit 0 -> grantIndex stays 4.
// 6 Reset while grantValid = 1 and pending = 32'hFF -> next edge grantValid = 0, pending = 0.
//   The following grant after a new pulse starts from index 0.

Source files
------------

// File: rtl/pending_request_arbiter.sv
// pending_request_arbiter
//   Registered successor to the combinational priority encoder. Request pulses
//   are latched into sticky pending bits; a per-line mask selects which pending
//   lines may win. One winner (fixed lowest-index-first, or round-robin after
//   the last accepted grant) is offered on a valid/ready grant handshake.
//
// Ports
//   clock           in   single clock, rising edge
//   reset           in   synchronous, active-high
//   requestPulses   in   [WIDTH]        1 sets the corresponding pending bit
//   requestMask     in   [WIDTH]        1 = line eligible; masked lines stay pending
//   grantReady      in   consumer accepts the current grant
//   pendingSignals  out  [WIDTH]        registered pending bits (unmasked)
//   anyPending      out  |(pending & mask)
//   grantValid      out  registered grant offer
//   grantIndex      out  [INDEX_WIDTH]  registered winner, stable while grantValid
module pending_request_arbiter #(
   parameter int WIDTH       = 32,
   parameter int INDEX_WIDTH = 5,
   parameter int ROUND_ROBIN = 0
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [WIDTH-1:0]       requestPulses,
   input  logic [WIDTH-1:0]       requestMask,
   input  logic                   grantReady,
   output logic [WIDTH-1:0]       pendingSignals,
   output logic                   anyPending,
   output logic                   grantValid,
   output logic [INDEX_WIDTH-1:0] grantIndex
);

   typedef enum logic {ST_IDLE, ST_GRANT} state_t;

   state_t                 state_q, state_d;
   logic [WIDTH-1:0]       pending_q, pending_d;
   logic [INDEX_WIDTH-1:0] grant_idx_q, grant_idx_d;
   logic [INDEX_WIDTH-1:0] last_q, last_d;

   logic [WIDTH-1:0]       eligible;
   logic [WIDTH-1:0]       clr_vec;
   logic                   accept;
   logic [INDEX_WIDTH-1:0] rr_start;
   logic [INDEX_WIDTH-1:0] win_hi, win_lo, winner;
   logic                   found_hi;

   // Arbitration looks only at registered pending bits, never this cycle's pulses.
   assign eligible = pending_q & requestMask;
   assign accept   = (state_q == ST_GRANT) && grantReady;

   // Clear the granted line on accept; a same-cycle pulse re-sets it.
   always_comb begin
      clr_vec = '0;
      for (int i = 0; i < WIDTH; i++)
         clr_vec[i] = accept && (grant_idx_q == INDEX_WIDTH'(i));
      pending_d = (pending_q & ~clr_vec) | requestPulses;
   end

   // Winner search. rr_start is 0 in fixed mode, so win_hi is simply the lowest
   // eligible line. In round-robin mode win_hi is the lowest eligible line at or
   // above lastGranted+1; if none exists the scan wraps and win_lo is used.
   always_comb begin
      rr_start = '0;
      if (ROUND_ROBIN != 0 && last_q != INDEX_WIDTH'(WIDTH - 1))
         rr_start = last_q + 1'b1;
      win_hi   = '0;
      win_lo   = '0;
      found_hi = 1'b0;
      // Descending scan: the last assignment is the lowest matching index.
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            win_lo = INDEX_WIDTH'(i);
            if (INDEX_WIDTH'(i) >= rr_start) begin
               win_hi   = INDEX_WIDTH'(i);
               found_hi = 1'b1;
            end
         end
      end
      winner = found_hi ? win_hi : win_lo;
   end

   // Grant FSM: no preemption while a grant is outstanding; one IDLE bubble per accept.
   always_comb begin
      state_d     = state_q;
      grant_idx_d = grant_idx_q;
      last_d      = last_q;
      case (state_q)
         ST_IDLE: begin
            if (|eligible) begin
               grant_idx_d = winner;
               state_d     = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (grantReady) begin
               last_d  = grant_idx_q;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         pending_q   <= '0;
         grant_idx_q <= '0;
         last_q      <= INDEX_WIDTH'(WIDTH - 1);
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         grant_idx_q <= grant_idx_d;
         last_q      <= last_d;
      end
   end

   assign pendingSignals = pending_q;
   assign anyPending     = |eligible;
   assign grantValid     = (state_q == ST_GRANT);
   assign grantIndex     = grant_idx_q;

endmodule

// File: tb/tb_pending_request_arbiter.sv
module tb_pending_request_arbiter;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset;
   logic [31:0] pulses, mask;
   logic        ready;

   logic [31:0] pend32;
   logic        any32, gv32;
   logic [4:0]  gi32;
   logic [5:0]  pend6;
   logic        any6, gv6;
   logic [2:0]  gi6;

   pending_request_arbiter #(.WIDTH(32), .INDEX_WIDTH(5), .ROUND_ROBIN(0)) dut32 (
      .clock(clock), .reset(reset), .requestPulses(pulses), .requestMask(mask),
      .grantReady(ready), .pendingSignals(pend32), .anyPending(any32),
      .grantValid(gv32), .grantIndex(gi32));

   pending_request_arbiter #(.WIDTH(6), .INDEX_WIDTH(3), .ROUND_ROBIN(1)) dut6 (
      .clock(clock), .reset(reset), .requestPulses(pulses[5:0]), .requestMask(mask[5:0]),
      .grantReady(ready), .pendingSignals(pend6), .anyPending(any6),
      .grantValid(gv6), .grantIndex(gi6));

   typedef struct {
      bit [31:0] pend;
      bit        gv;
      int        gi;
      int        last;
      int        w;
      bit        rr;
   } mdl_t;

   typedef struct {
      bit [31:0] pend;
      bit        any;
      bit        gv;
      int        gi;
   } exp_t;

   mdl_t m32 = '{pend: 0, gv: 0, gi: 0, last: 31, w: 32, rr: 0};
   mdl_t m6  = '{pend: 0, gv: 0, gi: 0, last: 5,  w: 6,  rr: 1};
   exp_t e32_q[$], e6_q[$];
   int   g32_q[$], g6_q[$];
   int   checks = 0;
   int   errors = 0;

   function automatic bit [31:0] wmask(int w);
      bit [63:0] t;
      t = (64'd1 << w) - 64'd1;
      return t[31:0];
   endfunction

   // First eligible line scanning from lastGranted+1 (rr) or 0 (fixed), wrapping.
   function automatic int pick(mdl_t m, bit [31:0] elig);
      int start;
      int c;
      start = m.rr ? (m.last + 1) % m.w : 0;
      for (int k = 0; k < m.w; k++) begin
         c = (start + k) % m.w;
         if (elig[c]) return c;
      end
      return -1;
   endfunction

   function automatic mdl_t step(mdl_t m, bit r, bit [31:0] p, bit [31:0] mk, bit rd);
      mdl_t n;
      bit [31:0] elig;
      n = m;
      if (r) begin
         n.pend = 0; n.gv = 0; n.gi = 0; n.last = m.w - 1;
         return n;
      end
      elig = m.pend & mk & wmask(m.w);
      if (m.gv) begin
         if (rd) begin
            n.pend[m.gi] = 1'b0;
            n.gv   = 1'b0;
            n.last = m.gi;
         end
      end else if (elig != 0) begin
         n.gi = pick(m, elig);
         n.gv = 1'b1;
      end
      n.pend = n.pend | (p & wmask(m.w));
      return n;
   endfunction

   task automatic chk(string nm, bit [31:0] act, bit [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Drive one cycle of stimulus and queue what both DUTs should show after the edge.
   task automatic drive(bit r, bit [31:0] p, bit [31:0] mk, bit rd);
      exp_t e;
      reset = r; pulses = p; mask = mk; ready = rd;
      if (!r && m32.gv && rd) g32_q.push_back(m32.gi);
      if (!r && m6.gv && rd)  g6_q.push_back(m6.gi);
      m32 = step(m32, r, p, mk, rd);
      m6  = step(m6, r, p, mk, rd);
      e.pend = m32.pend; e.any = |(m32.pend & mk); e.gv = m32.gv; e.gi = m32.gi;
      e32_q.push_back(e);
      e.pend = m6.pend; e.any = |(m6.pend & mk & wmask(6)); e.gv = m6.gv; e.gi = m6.gi;
      e6_q.push_back(e);
      @(negedge clock);
   endtask

   // Monitor: compares every cycle, and pops the grant scoreboard on each accept.
   initial begin
      bit        pgv32, pgv6;
      bit [31:0] pgi32, pgi6;
      exp_t      e;
      pgv32 = 0; pgv6 = 0; pgi32 = 0; pgi6 = 0;
      forever begin
         @(posedge clock);
         #1;
         if (!reset && pgv32 && ready) begin
            if (g32_q.size() == 0) chk("grant32_unexpected", 1, 0);
            else chk("grant32_order", pgi32, g32_q.pop_front());
         end
         if (!reset && pgv6 && ready) begin
            if (g6_q.size() == 0) chk("grant6_unexpected", 1, 0);
            else chk("grant6_order", pgi6, g6_q.pop_front());
         end
         if (e32_q.size() > 0) begin
            e = e32_q.pop_front();
            chk("pend32", pend32, e.pend);
            chk("any32", {31'd0, any32}, {31'd0, e.any});
            chk("valid32", {31'd0, gv32}, {31'd0, e.gv});
            chk("index32", {27'd0, gi32}, e.gi);
         end
         if (e6_q.size() > 0) begin
            e = e6_q.pop_front();
            chk("pend6", {26'd0, pend6}, e.pend);
            chk("any6", {31'd0, any6}, {31'd0, e.any});
            chk("valid6", {31'd0, gv6}, {31'd0, e.gv});
            chk("index6", {29'd0, gi6}, e.gi);
         end
         pgv32 = gv32; pgi32 = {27'd0, gi32};
         pgv6  = gv6;  pgi6  = {29'd0, gi6};
      end
   end

   initial begin
      bit        r, rd;
      bit [31:0] p, mk;
      drive(1, 0, '1, 0);
      drive(1, 0, '1, 0);
      // single pulse on line 0, then accept
      drive(0, 32'h1, '1, 0);
      repeat (3) drive(0, 0, '1, 0);
      drive(0, 0, '1, 1);
      drive(0, 0, '1, 0);
      // fixed order 1, 2, 31 with ready held
      drive(0, 32'h8000_0006, '1, 1);
      repeat (8) drive(0, 0, '1, 1);
      // masked line 0 stays pending until unmasked
      drive(0, 32'h3, 32'hFFFF_FFFE, 1);
      repeat (6) drive(0, 0, 32'hFFFF_FFFE, 1);
      repeat (4) drive(0, 0, '1, 1);
      // lines 0 and 5 re-pulsed every cycle
      drive(1, 0, '1, 0);
      repeat (10) drive(0, 32'h21, '1, 1);
      repeat (4) drive(0, 0, '1, 1);
      // set dominates on the accepted line
      drive(0, 32'h8, '1, 0);
      repeat (3) drive(0, 0, '1, 0);
      drive(0, 32'h8, '1, 1);
      repeat (4) drive(0, 0, '1, 1);
      // no preemption of an outstanding grant
      drive(0, 32'h10, '1, 0);
      repeat (3) drive(0, 0, '1, 0);
      drive(0, 32'h1, '1, 0);
      repeat (3) drive(0, 0, '1, 0);
      repeat (5) drive(0, 0, '1, 1);
      // reset with a grant outstanding
      drive(0, 32'hFF, '1, 0);
      repeat (3) drive(0, 0, '1, 0);
      drive(1, 0, '1, 0);
      drive(0, 32'h11, '1, 0);
      repeat (3) drive(0, 0, '1, 0);
      repeat (3) drive(0, 0, '1, 1);
      // random traffic
      for (int i = 0; i < 400; i++) begin
         r  = ($urandom_range(0, 63) == 0);
         p  = $urandom & $urandom & $urandom;
         mk = ($urandom_range(0, 3) == 0) ? $urandom : 32'hFFFF_FFFF;
         rd = 1'($urandom_range(0, 1));
         drive(r, p, mk, rd);
      end
      repeat (2) drive(0, 0, '1, 0);
      repeat (3) @(negedge clock);
      chk("drain", e32_q.size() + e6_q.size() + g32_q.size() + g6_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
